// File: rtl/enemy_spawner.sv
// enemy_spawner: drives the per-slot enable and 16-bit control word of
// NUM_SLOTS enemy instances from the frame-clock domain. After game_en rises,
// slots are enabled one at a time with a fixed spacing (RAMP). Once every slot
// is enabled, control words are rewritten round-robin (FULL). A difficulty
// level rises over time. Each level shortens the spawn interval and raises the
// speed field of newly written words.
//
// Configuration macro: SPAWNER_LEVEL_RAMP_EN
//   defined     - level ramp active (frame counter, shrinking interval, speed)
//   not defined - level fixed at 0, interval fixed at BASE_INTERVAL, speed 0
//
// Ports:
//   frame_clk  in   clock, one edge per video frame
//   rst        in   asynchronous, active-high reset
//   game_en    in   run request; low returns to IDLE and clears outputs
//   pause      in   freezes all state and outputs while high
//   en         out  per-slot enable, bit i drives enemy i
//   control    out  control word of slot i in bits [16i+15:16i]
//                   ([9:0] x start, [10] flip, [12:11] speed, [15:13] zero)
//   level      out  current difficulty level, 0..7
//   active_cnt out  number of enabled slots
module enemy_spawner #(
    parameter int unsigned NUM_SLOTS     = 4,
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int unsigned BASE_INTERVAL = 60,
    parameter int unsigned INTERVAL_STEP = 8,
    parameter int unsigned MIN_INTERVAL  = 16,
    parameter int unsigned LEVEL_FRAMES  = 600
) (
    input  logic                      frame_clk,
    input  logic                      rst,
    input  logic                      game_en,
    input  logic                      pause,
    output logic [NUM_SLOTS-1:0]      en,
    output logic [16*NUM_SLOTS-1:0]   control,
    output logic [2:0]                level,
    output logic [3:0]                active_cnt
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CW     = WORD_W * NUM_SLOTS;
    localparam int unsigned TW     = 16;
    localparam int unsigned PW     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [15:0]          lfsr, lfsr_nxt;
    logic [TW-1:0]        timer, timer_nxt;
    logic [PW-1:0]        ptr, ptr_nxt;
    logic [2:0]           level_nxt;
    logic [NUM_SLOTS-1:0] en_nxt;
    logic [CW-1:0]        control_nxt;
    logic [3:0]           active_cnt_nxt;
    logic [WORD_W-1:0]    word_c;
    logic [TW-1:0]        interval_c;

`ifdef SPAWNER_LEVEL_RAMP_EN
    localparam int unsigned FW = $clog2(LEVEL_FRAMES);
    logic [FW-1:0] frame_cnt, frame_nxt;
`else
    logic unused_cfg;
    assign unused_cfg = ^32'(LEVEL_FRAMES);
`endif

    // Spawn interval for a given level, clamped at MIN_INTERVAL.
    function automatic logic [TW-1:0] interval_of(input logic [2:0] lvl);
        int v;
        v = int'(BASE_INTERVAL) - int'(lvl) * int'(INTERVAL_STEP);
        if (v < int'(MIN_INTERVAL)) begin
            v = int'(MIN_INTERVAL);
        end
        return TW'(v);
    endfunction

    // Control word from the current LFSR value; x folded into 0..639.
    function automatic logic [WORD_W-1:0] make_word(input logic [15:0] l,
                                                    input logic [2:0]  lvl);
        logic [9:0] x;
        x = (l[9:0] < 10'd640) ? l[9:0] : (l[9:0] - 10'd512);
        // level>>1 never exceeds 3 for a 3-bit level, so no clamp is needed.
        return {3'b000, lvl[2:1], l[10], x};
    endfunction

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left into bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    assign word_c     = make_word(lfsr, level);
    assign interval_c = interval_of(level);

    // State register and registered outputs.
    always_ff @(posedge frame_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= SEED;
            timer      <= '0;
            ptr        <= '0;
            level      <= '0;
            en         <= '0;
            control    <= '0;
            active_cnt <= '0;
        end else begin
            state      <= state_nxt;
            lfsr       <= lfsr_nxt;
            timer      <= timer_nxt;
            ptr        <= ptr_nxt;
            level      <= level_nxt;
            en         <= en_nxt;
            control    <= control_nxt;
            active_cnt <= active_cnt_nxt;
        end
    end

`ifdef SPAWNER_LEVEL_RAMP_EN
    // Running-frame counter that paces level increments.
    always_ff @(posedge frame_clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_nxt;
        end
    end
`endif

    // Next-state and output logic; game_en low outranks pause and spawns.
    always_comb begin
        state_nxt   = state;
        lfsr_nxt    = lfsr;
        timer_nxt   = timer;
        ptr_nxt     = ptr;
        level_nxt   = level;
        en_nxt      = en;
        control_nxt = control;
`ifdef SPAWNER_LEVEL_RAMP_EN
        frame_nxt   = frame_cnt;
`endif

        if (!game_en) begin
            state_nxt   = IDLE;
            timer_nxt   = '0;
            ptr_nxt     = '0;
            level_nxt   = '0;
            en_nxt      = '0;
            control_nxt = '0;
`ifdef SPAWNER_LEVEL_RAMP_EN
            frame_nxt   = '0;
`endif
        end else if (!pause) begin
            lfsr_nxt = lfsr_step(lfsr);
            unique case (state)
                IDLE: begin
                    control_nxt[WORD_W-1:0] = word_c;
                    en_nxt[0]               = 1'b1;
                    ptr_nxt                 = PW'(1);
                    timer_nxt               = interval_c - TW'(1);
                    state_nxt               = RAMP;
                end
                RAMP, FULL: begin
`ifdef SPAWNER_LEVEL_RAMP_EN
                    if (frame_cnt == FW'(LEVEL_FRAMES - 1)) begin
                        frame_nxt = '0;
                        if (level != 3'd7) begin
                            level_nxt = level + 3'd1;
                        end
                    end else begin
                        frame_nxt = frame_cnt + FW'(1);
                    end
`endif
                    if (timer == '0) begin
                        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                            if (ptr == PW'(i)) begin
                                control_nxt[i*WORD_W +: WORD_W] = word_c;
                                en_nxt[i]                       = 1'b1;
                            end
                        end
                        // Reload uses the level in effect before this edge.
                        timer_nxt = interval_c - TW'(1);
                        if (ptr == PW'(NUM_SLOTS - 1)) begin
                            ptr_nxt   = '0;
                            state_nxt = FULL;
                        end else begin
                            ptr_nxt = ptr + PW'(1);
                        end
                    end else begin
                        timer_nxt = timer - TW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Registered popcount of the next enable vector.
    always_comb begin
        active_cnt_nxt = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            active_cnt_nxt = active_cnt_nxt + 4'(en_nxt[i]);
        end
    end

endmodule

// File: doc/enemy_spawner.md
# enemy_spawner

Drives the `control` and `en` inputs of `NUM_SLOTS` enemy instances from the frame-clock domain. It staggers slot activation and issues LFSR-randomised 16-bit control words: x start, flip and speed. It also raises a difficulty level over time, shortening the spawn interval and raising the speed field. The block sits between game-state logic and the enemy array, which samples its control word whenever it respawns.

## Interface
Parameters:
- `NUM_SLOTS`, 4: number of enemy slots driven (2..8).
- `SEED`, 16'hACE1: LFSR reset value; must be non-zero.
- `BASE_INTERVAL`, 60: frames between spawn events at level 0.
- `INTERVAL_STEP`, 8: interval reduction per level.
- `MIN_INTERVAL`, 16: interval floor.
- `LEVEL_FRAMES`, 600: running frames per level increment.

Ports:
- `frame_clk`  in  1  clock, one edge per video frame.
- `rst`  in  1  asynchronous, active-high reset.
- `game_en`  in  1  run request; low forces IDLE.
- `pause`  in  1  freezes all state while high.
- `en`  out  NUM_SLOTS  per-slot enable, bit i drives enemy i.
- `control`  out  16*NUM_SLOTS  control word for slot i in bits [16i+15:16i].
- `level`  out  3  current difficulty, 0..7.
- `active_cnt`  out  4  number of enabled slots.

## Operation
- Control word fields:
  - [9:0] = x: `lfsr[9:0]` if below 640, else `lfsr[9:0]` minus 512.
  - [10] = flip: `lfsr[10]`.
  - [12:11] = speed: min(level>>1, 3).
  - [15:13] = 0.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifts left, feedback into bit 0.
  - Advances on every edge where `game_en`=1 and `pause`=0.
  - Not cleared by leaving RUN; only `rst` reloads `SEED`.
  - A control word always uses the pre-advance LFSR value of that edge.
- Spawn interval = max(`BASE_INTERVAL` − level·`INTERVAL_STEP`, `MIN_INTERVAL`). It is evaluated at timer reload, using the current (pre-increment) level.
- State machine:
  - IDLE: all `en`=0, all `control`=0, level and counters cleared.
    - Leaves when `game_en`=1 and `pause`=0. On that edge it writes slot 0, sets `en[0]`, sets slot pointer to 1, loads timer = interval−1 and enters RAMP.
  - RAMP: timer decrements each unpaused edge.
    - At timer==0: write the control word of the pointer slot, set its `en`, increment the pointer and reload the timer.
    - Writing slot `NUM_SLOTS`−1 wraps the pointer to 0 and enters FULL.
  - FULL: at timer==0, rewrite the control word of the pointer slot (round-robin, wrap at `NUM_SLOTS`−1) and reload the timer. `en` stays all-ones.
- Level: a frame counter runs in RAMP/FULL on unpaused edges. At `LEVEL_FRAMES`−1 it wraps to 0 and level increments, saturating at 7.
- `game_en` low in any state: the next edge enters IDLE with the IDLE clears. It has priority over spawn events on the same edge.
- `pause` high: state, timer, pointer, level, frame counter and LFSR hold; outputs hold.
- `active_cnt` = popcount of `en`.

## Timing
- All outputs are registered. Reset values: `en`=0, `control`=0, `level`=0, `active_cnt`=0; state IDLE, LFSR=`SEED`.
- Spawn in the same edge that leaves IDLE: `en[0]` and the slot 0 word are visible after the first edge with `game_en`=1.
- Slot k (k≥1) is enabled exactly k·interval edges after that first edge, assuming no pause or level change.
- A control word changes only on the edge its slot is written. It is stable otherwise, so an enemy's mid-flight respawn samples a consistent word.
- `rst` asserted mid-operation returns everything to reset values immediately, without waiting for a clock edge.

## Configuration
- `SPAWNER_LEVEL_RAMP_EN` defined: level ramp active as described.
- Not defined: level is tied to 0, the frame counter is removed, interval is fixed at `BASE_INTERVAL` and speed is fixed at 0.

## Test plan
All scenarios use default parameters with `SPAWNER_LEVEL_RAMP_EN` defined unless stated.
- Reset, then `game_en`=1 -> after edge 1: `en`=4'b0001, `control[15:0]`=16'h04E1, `active_cnt`=1.
- Continue unpaused -> `en`=0011 at edge 61, 0111 at edge 121, 1111 at edge 181 (FULL). At edge 241 the slot 0 word is rewritten and `en` is unchanged.
- Run 600 unpaused frames -> `level`=1, next reload uses interval 52. After 4200 frames `level`=7; interval clamps to 16; speed field=3.
- Assert `pause` for 100 edges in RAMP -> `en`, `control`, LFSR, timer and `level` are unchanged. Schedule resumes shifted by exactly 100 edges.
- Drop `game_en` in FULL -> next edge `en`=0, `control`=0, `level`=0. Re-raise -> slot 0 word uses the continued (non-`SEED`) LFSR value.
- `SPAWNER_LEVEL_RAMP_EN` undefined, run 5000 frames -> `level`=0, every speed field=0, rewrite period stays 60.
